// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues loads/stores to a multi-cycle data memory,
// stalls the pipeline while it is busy and produces the MEM/WB result/bubble/error.
module mem_access_ctrl #(
  parameter int W   = 16,
  parameter int TMO = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic         mem_rd_in,
  input  logic         mem_wr_in,
  input  logic [W-1:0] addr_in,
  input  logic [W-1:0] wdata_in,
  output logic         mem_en,
  output logic         mem_wr,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_stall,
  input  logic         mem_done,
  output logic         stall_o,
  output logic [W-1:0] ReadData_o,
  output logic         wait_o,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [7:0] TmoCnt = 8'(TMO);

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic           is_rd_q, is_rd_d;

  logic mem_op, bad_op, acc;

  // Odd addresses and simultaneous read+write only matter for real memory ops.
  assign mem_op = valid_in & (mem_rd_in | mem_wr_in);
  assign bad_op = mem_op & (addr_in[0] | (mem_rd_in & mem_wr_in));
  assign acc    = mem_op & ~bad_op;

  assign mem_addr  = addr_in;
  assign mem_wdata = wdata_in;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      is_rd_q <= is_rd_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    is_rd_d    = is_rd_q;
    mem_en     = 1'b0;
    mem_wr     = mem_wr_in;
    stall_o    = 1'b0;
    wait_o     = 1'b1;
    ReadData_o = '0;
    err        = 1'b0;

    unique case (state_q)
      IDLE: begin
        mem_en = acc;
        if (bad_op) begin
          err = 1'b1;
        end else if (acc && mem_stall) begin
          stall_o = 1'b1;
          err     = mem_done;
        end else if (acc && mem_done) begin
          wait_o     = 1'b0;
          ReadData_o = mem_rd_in ? mem_rdata : '0;
        end else if (acc) begin
          stall_o = 1'b1;
          state_d = BUSY;
          cnt_d   = 8'd1;
          is_rd_d = mem_rd_in;
        end else begin
          wait_o = ~valid_in;
          err    = mem_done;
        end
      end

      BUSY: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (mem_done) begin
          rdata_d = is_rd_q ? mem_rdata : '0;
          state_d = RESP;
        end else if (cnt_q == TmoCnt) begin
          // Abort a stuck access so the pipeline cannot deadlock.
          err     = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end

      RESP: begin
        wait_o     = 1'b0;
        ReadData_o = rdata_q;
        err        = mem_done;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      stall_o    = 1'b0;
      wait_o     = 1'b1;
      ReadData_o = '0;
      err        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a cycle-level behavioural model checked every
// negedge, plus directed scenarios with hand-computed literal expectations.
module tb_mem_access_ctrl;

  localparam int W   = 16;
  localparam int TMO = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in, mem_rd_in, mem_wr_in;
  logic [W-1:0] addr_in, wdata_in, mem_rdata;
  logic         mem_stall, mem_done;
  logic         mem_en, mem_wr, stall_o, wait_o, err;
  logic [W-1:0] mem_addr, mem_wdata, ReadData_o;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
    .stall_o(stall_o), .ReadData_o(ReadData_o), .wait_o(wait_o), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an access in flight, how many cycles it has waited, and a pending response.
  bit          m_busy, m_resp, m_rd;
  int          m_waited;
  logic [15:0] m_data;

  function automatic bit f_memop();
    return valid_in && (mem_rd_in || mem_wr_in);
  endfunction

  function automatic bit f_bad();
    return f_memop() && (addr_in[0] || (mem_rd_in && mem_wr_in));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_resp = 0; m_rd = 0; m_waited = 0; m_data = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (mem_done) begin
        m_data = m_rd ? mem_rdata : 16'h0;
        m_busy = 0; m_resp = 1;
      end else if (m_waited == TMO) begin
        m_data = 16'h0;
        m_busy = 0; m_resp = 1;
      end else begin
        m_waited++;
      end
    end else if (f_memop() && !f_bad() && !mem_stall && !mem_done) begin
      m_busy = 1; m_waited = 1; m_rd = mem_rd_in;
    end
  end

  always @(negedge clk) begin : cmp
    logic e_en, e_wr, e_stall, e_wait, e_err;
    logic [15:0] e_rd;
    e_en = 0; e_wr = mem_wr_in; e_stall = 0; e_wait = 1; e_err = 0; e_rd = 16'h0;
    if (rst) begin
      e_wr = 0;
    end else if (m_resp) begin
      e_wait = 0; e_rd = m_data; e_err = mem_done;
    end else if (m_busy) begin
      e_stall = 1; e_err = !mem_done && (m_waited == TMO);
    end else if (f_bad()) begin
      e_err = 1;
    end else if (f_memop()) begin
      e_en = 1;
      if (mem_stall) begin
        e_stall = 1; e_err = mem_done;
      end else if (mem_done) begin
        e_wait = 0; e_rd = mem_rd_in ? mem_rdata : 16'h0;
      end else begin
        e_stall = 1;
      end
    end else begin
      e_wait = !valid_in; e_err = mem_done;
    end
    check("ctrl{en,wr,stall,wait,err}", {27'd0, mem_en, mem_wr, stall_o, wait_o, err},
          {27'd0, e_en, e_wr, e_stall, e_wait, e_err});
    check("ReadData_o", {16'd0, ReadData_o}, {16'd0, e_rd});
    check("addr/wdata passthrough", {mem_addr, mem_wdata}, {addr_in, wdata_in});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic st, input logic dn, input logic [15:0] rdat);
    valid_in = v; mem_rd_in = rd; mem_wr_in = wr; addr_in = a; wdata_in = wd;
    mem_stall = st; mem_done = dn; mem_rdata = rdat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    rst = 1'b1;
    drv(1, 1, 0, 16'h0010, 16'h0, 0, 1, 16'hFFFF);
    @(negedge clk);
    check("rst_forced {en,wr,stall,wait,err}", {27'd0, mem_en, mem_wr, stall_o, wait_o, err}, 32'h02);
    check("rst_ReadData", ReadData_o, 32'h0);
    step();
    rst = 1'b0;
    drv(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    check("idle_bubble_wait", wait_o, 1);

    step(); drv(1, 0, 0, 16'h0003, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    check("nonmem_wait", wait_o, 0);
    check("nonmem_err", err, 0);

    // Load hit
    step(); drv(1, 1, 0, 16'h0010, 16'h0, 0, 1, 16'hBEEF);
    @(negedge clk);
    check("hit_ReadData", ReadData_o, 32'hBEEF);
    check("hit_stall_wait_err", {stall_o, wait_o, err}, 3'b000);

    // Load miss: done in the third cycle after accept, RESP in the fourth
    step(); drv(1, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0);
    @(negedge clk); check("miss_c0_stall", stall_o, 1);
    step(); @(negedge clk); check("miss_c1_stall", stall_o, 1);
    step(); mem_done = 1; mem_rdata = 16'h1234;
    @(negedge clk); check("miss_c2_stall_en", {stall_o, mem_en}, 2'b10);
    step(); mem_done = 0; mem_rdata = 16'h0;
    @(negedge clk);
    check("miss_resp_ReadData", ReadData_o, 32'h1234);
    check("miss_resp_stall_wait", {stall_o, wait_o}, 2'b00);

    // Busy memory, then a store hit
    step(); drv(1, 0, 1, 16'h0040, 16'hCAFE, 1, 0, 16'h0);
    @(negedge clk); check("busy_c0", {mem_en, stall_o, wait_o}, 3'b111);
    step(); @(negedge clk); check("busy_c1", {mem_en, stall_o, wait_o}, 3'b111);
    step(); mem_stall = 0; mem_done = 1;
    @(negedge clk);
    check("busy_c2_en_wr_stall_wait", {mem_en, mem_wr, stall_o, wait_o}, 4'b1100);
    check("busy_c2_ReadData", ReadData_o, 32'h0);

    // Illegal requests
    step(); drv(1, 1, 0, 16'h0011, 16'h0, 0, 0, 16'h0);
    @(negedge clk); check("unaligned", {mem_en, err, wait_o, stall_o}, 4'b0110);
    step(); drv(1, 1, 1, 16'h0012, 16'h0, 0, 0, 16'h0);
    @(negedge clk); check("rd_and_wr", {mem_en, err, wait_o, stall_o}, 4'b0110);
    step(); drv(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h0);
    @(negedge clk); check("stray_done_idle", err, 1);

    // Store miss; mem_done during RESP is an error
    step(); drv(1, 0, 1, 16'h0050, 16'h1111, 0, 0, 16'h0);
    step(); mem_done = 1; mem_rdata = 16'h7777;
    step();
    @(negedge clk);
    check("resp_done_err", err, 1);
    check("store_resp_ReadData", ReadData_o, 32'h0);

    // Timeout
    step(); drv(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0);
    found = -1;
    for (int c = 0; c < TMO + 8; c++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        found = c;
        break;
      end
      step();
    end
    check("timeout_cycle", found, 32);
    step();
    @(negedge clk);
    check("timeout_resp", {16'd0, ReadData_o}, 32'h0);
    check("timeout_resp_wait_err", {wait_o, err, stall_o}, 3'b000);
    step(); drv(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    @(negedge clk); check("after_timeout_idle", stall_o, 0);

    // mem_done on the timeout cycle wins without error
    step(); drv(1, 1, 0, 16'h0070, 16'h0, 0, 0, 16'h0);
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      step();
    end
    mem_done = 1; mem_rdata = 16'hA5A5;
    @(negedge clk); check("tie_no_err", err, 0);
    step(); mem_done = 0; mem_rdata = 16'h0;
    @(negedge clk); check("tie_ReadData", ReadData_o, 32'hA5A5);

    // Reset during BUSY
    step(); drv(1, 1, 0, 16'h0080, 16'h0, 0, 0, 16'h0);
    step(); step();
    #2 rst = 1'b1;
    #1 check("rst_busy_stall_wait_en", {stall_o, wait_o, mem_en}, 3'b010);
    @(posedge clk); #1;
    rst = 1'b0;
    drv(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h0);
    @(negedge clk); check("post_rst_stray_done", err, 1);
    step(); drv(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
